// File: rtl/tinycpu_pkg.sv
// Shared encodings for the tinycpu slice: CPU execution state and the
// memory-responder handshake FSM.
package tinycpu_pkg;

  typedef enum logic [1:0] {
    EX_FETCH     = 2'd0,
    EX_DECODE    = 2'd1,
    EX_EXECUTE   = 2'd2,
    EX_WRITEBACK = 2'd3
  } exec_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memresp_state_e;

  localparam int ACC_W  = 16;
  localparam int WCNT_W = 4;

endpackage

// File: rtl/tinycpu_ram.sv
// Single-port synchronous word array with write enable and registered read;
// contents are never reset.
module tinycpu_ram #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [IW-1:0] idx;

  // Callers only enable an access for in-range addresses, so the low bits suffice.
  assign idx = addr_i[IW-1:0];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tinycpu_memresp.sv
// Memory responder for the tinycpu: valid/ready request, fixed wait cycles,
// held response with error flag for out-of-range addresses, access counter.
module tinycpu_memresp
  import tinycpu_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int WAITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic [ACC_W-1:0] acc_count
);

  localparam logic [AW:0]       DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [WCNT_W-1:0] WAITS_L = WCNT_W'(WAITS);

  memresp_state_e    state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              err_q, err_d;
  logic              write_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;

  logic              accept;
  logic              enter_resp;
  logic              eff_write;
  logic [AW-1:0]     eff_addr;
  logic [DW-1:0]     eff_wdata;
  logic              in_range;
  logic              ram_we, ram_re;
  logic [DW-1:0]     ram_rdata;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // With WAITS=0 the memory access happens on the accept edge, before the
  // request registers hold it, so the live inputs are used in IDLE.
  assign eff_write = (state_q == IDLE) ? req_write : write_q;
  assign eff_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign in_range  = ({1'b0, eff_addr} < DEPTH_L);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAITS_L == '0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAITS_L;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WCNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - WCNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          acc_d   = acc_q + ACC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) err_d = !in_range;
  end

  // Reset must also veto a commit that would otherwise land on the same edge.
  assign ram_we = enter_resp && eff_write  && in_range && !reset;
  assign ram_re = enter_resp && !eff_write && in_range && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  tinycpu_ram #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (eff_addr),
    .wdata_i (eff_wdata),
    .rdata_o (ram_rdata)
  );

  // The RAM read register only changes on entry to RESP, so data stays stable.
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? ram_rdata : '0;
  assign acc_count = acc_q;

endmodule
